// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one physical-memory port between the I-cache and
// the D-cache. One 128-bit line transaction is granted at a time. D-side wins
// contention, but a streak counter forces a waiting I request through after
// STARVE_LIMIT consecutive contended D grants.
module cache_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         icache_pmem_read,
  input  logic [15:0]  icache_pmem_address,
  output logic [127:0] icache_pmem_rdata,
  output logic         icache_pmem_resp,
  input  logic         dcache_pmem_read,
  input  logic         dcache_pmem_write,
  input  logic [15:0]  dcache_pmem_address,
  input  logic [127:0] dcache_pmem_wdata,
  output logic [127:0] dcache_pmem_rdata,
  output logic         dcache_pmem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic         arb_busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  localparam logic [3:0]  LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [15:0] LINE_MASK = 16'hFFF0;

  logic [1:0]   state_q, state_d;
  logic [3:0]   d_streak_q, d_streak_d;
  logic [15:0]  addr_q, addr_d;
  logic [127:0] wdata_q, wdata_d;
  logic         wflag_q, wflag_d;

  logic i_req;
  logic d_req;
  logic force_i;

  assign i_req   = icache_pmem_read;
  // Read and write together is treated as a write via wflag below.
  assign d_req   = dcache_pmem_read | dcache_pmem_write;
  // I is forced through only when it is actually waiting and D has used up its streak.
  assign force_i = i_req && (d_streak_q == LIMIT);

  // Grant decision, request latching and streak bookkeeping.
  always_comb begin
    state_d    = state_q;
    d_streak_d = d_streak_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wflag_d    = wflag_q;
    case (state_q)
      IDLE: begin
        if (d_req && !force_i) begin
          state_d = SERVE_D;
          addr_d  = dcache_pmem_address & LINE_MASK;
          wflag_d = dcache_pmem_write;
          wdata_d = dcache_pmem_wdata;
          if (i_req && (d_streak_q < LIMIT)) begin
            d_streak_d = d_streak_q + 4'd1;
          end
        end else if (i_req) begin
          state_d    = SERVE_I;
          addr_d     = icache_pmem_address & LINE_MASK;
          wflag_d    = 1'b0;
          wdata_d    = '0;
          d_streak_d = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        // Always return through IDLE so the requester can drop a finished request.
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      d_streak_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wflag_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_streak_q <= d_streak_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wflag_q    <= wflag_d;
    end
  end

  assign pmem_read    = (state_q == SERVE_I) || ((state_q == SERVE_D) && !wflag_q);
  assign pmem_write   = (state_q == SERVE_D) && wflag_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign arb_busy     = (state_q != IDLE);

  // Responses route only to the granted side; a resp seen in IDLE is dropped.
  assign icache_pmem_resp  = (state_q == SERVE_I) && pmem_resp;
  assign dcache_pmem_resp  = (state_q == SERVE_D) && pmem_resp;
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a scoreboard of expected
// transactions, popped and compared whenever a cache response pulses.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         icache_pmem_read;
  logic [15:0]  icache_pmem_address;
  logic [127:0] icache_pmem_rdata;
  logic         icache_pmem_resp;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [15:0]  dcache_pmem_address;
  logic [127:0] dcache_pmem_wdata;
  logic [127:0] dcache_pmem_rdata;
  logic         dcache_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         arb_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           own_d;
    logic [15:0]  addr;
    bit           wr;
    logic [127:0] wdata;
  } exp_t;

  exp_t sb[$];

  cache_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp),
    .arb_busy            (arb_busy)
  );

  always #5 clk = ~clk;

  // Memory line contents as a function of the line address.
  function automatic logic [127:0] rdf(input logic [15:0] a);
    rdf = {8{a}} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Memory responder: waits (bounded) for a command, holds it lat cycles, pulses resp.
  task automatic mem_serve(input int lat, output int waited);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pmem_read || pmem_write) && n < 40);
    waited = n;
    chk1("mem_cmd_arrives", pmem_read || pmem_write, 1'b1);
    if (pmem_read || pmem_write) begin
      for (int k = 1; k < lat; k++) begin
        @(posedge clk); #1;
        chk1("cmd_held", pmem_read || pmem_write, 1'b1);
      end
      pmem_rdata = rdf(pmem_address);
      pmem_resp  = 1'b1;
      @(posedge clk); #1;
      pmem_resp  = 1'b0;
      pmem_rdata = {4{$urandom}};
      chk1("idle_after_resp", arb_busy, 1'b0);
      chk1("cmd_drop_after_resp", pmem_read || pmem_write, 1'b0);
    end
  endtask

  // Response monitor: every cache resp must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (icache_pmem_resp || dcache_pmem_resp) begin
        chk1("resp_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk1("resp_i_owner", icache_pmem_resp, !e.own_d);
          chk1("resp_d_owner", dcache_pmem_resp, e.own_d);
          chk("resp_addr", 128'(pmem_address), 128'(e.addr));
          chk1("resp_write", pmem_write, e.wr);
          chk1("resp_read", pmem_read, !e.wr);
          if (e.wr) chk("resp_wdata", pmem_wdata, e.wdata);
          chk("resp_rdata", e.own_d ? dcache_pmem_rdata : icache_pmem_rdata, rdf(e.addr));
        end
      end
    end
  end

  // Global time bound.
  initial begin
    #300000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int w;
    exp_t e;
    reset = 1'b1;
    icache_pmem_read = 1'b0; icache_pmem_address = '0;
    dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    dcache_pmem_address = '0; dcache_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk1("rst_read", pmem_read, 1'b0);
    chk1("rst_write", pmem_write, 1'b0);
    chk1("rst_busy", arb_busy, 1'b0);
    chk1("rst_iresp", icache_pmem_resp, 1'b0);
    chk1("rst_dresp", dcache_pmem_resp, 1'b0);
    chk("rst_addr", 128'(pmem_address), 128'(0));
    chk("rst_wdata", pmem_wdata, 128'(0));
    chk("rst_streak", 128'(dut.d_streak_q), 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // I read alone, latency 3.
    e = '{own_d: 1'b0, addr: 16'h1230, wr: 1'b0, wdata: '0}; sb.push_back(e);
    icache_pmem_read = 1'b1; icache_pmem_address = 16'h1234;
    mem_serve(3, w);
    chk1("i_grant_latency", w == 2, 1'b1);
    icache_pmem_read = 1'b0;
    @(posedge clk); #1;
    chk1("no_stale_regrant", arb_busy, 1'b0);

    // I and D raised together: D first, then I after the IDLE turnaround.
    e = '{own_d: 1'b1, addr: 16'h0100, wr: 1'b0, wdata: '0}; sb.push_back(e);
    e = '{own_d: 1'b0, addr: 16'h0A00, wr: 1'b0, wdata: '0}; sb.push_back(e);
    icache_pmem_read = 1'b1; icache_pmem_address = 16'h0A08;
    dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h010C;
    mem_serve(2, w);
    dcache_pmem_read = 1'b0;
    @(posedge clk); #1;
    chk1("i_after_d_busy", arb_busy, 1'b1);
    chk1("i_after_d_read", pmem_read, 1'b1);
    chk("i_after_d_addr", 128'(pmem_address), 128'(16'h0A00));
    mem_serve(2, w);
    icache_pmem_read = 1'b0;
    @(posedge clk); #1;

    // D writeback; requester wdata/address change mid-transaction.
    e = '{own_d: 1'b1, addr: 16'h0400, wr: 1'b1, wdata: {32{4'hA}}}; sb.push_back(e);
    dcache_pmem_write = 1'b1; dcache_pmem_address = 16'h0400; dcache_pmem_wdata = {32{4'hA}};
    @(posedge clk); #1;
    dcache_pmem_wdata = {32{4'h5}}; dcache_pmem_address = 16'h0FF0;
    chk1("wb_write", pmem_write, 1'b1);
    chk1("wb_read", pmem_read, 1'b0);
    chk("wb_wdata_latched", pmem_wdata, {32{4'hA}});
    chk("wb_addr_latched", 128'(pmem_address), 128'(16'h0400));
    mem_serve(3, w);
    dcache_pmem_write = 1'b0;
    @(posedge clk); #1;

    // Starvation: I held, D continuously requesting new lines.
    for (int k = 0; k < 4; k++) begin
      e = '{own_d: 1'b1, addr: 16'h3000 + 16'(k * 16), wr: 1'b0, wdata: '0}; sb.push_back(e);
    end
    e = '{own_d: 1'b0, addr: 16'h2000, wr: 1'b0, wdata: '0}; sb.push_back(e);
    e = '{own_d: 1'b1, addr: 16'h3040, wr: 1'b0, wdata: '0}; sb.push_back(e);
    icache_pmem_read = 1'b1; icache_pmem_address = 16'h2000;
    dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h3000;
    for (int k = 0; k < 4; k++) begin
      mem_serve(2, w);
      dcache_pmem_address = 16'h3000 + 16'((k + 1) * 16);
    end
    chk("streak_saturated", 128'(dut.d_streak_q), 128'(4));
    mem_serve(2, w);
    icache_pmem_read = 1'b0;
    chk("streak_cleared", 128'(dut.d_streak_q), 128'(0));
    mem_serve(2, w);
    dcache_pmem_read = 1'b0;
    @(posedge clk); #1;

    // Reset two cycles into a D read abandons it.
    dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h0800;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1("pre_reset_read", pmem_read, 1'b1);
    reset = 1'b1; dcache_pmem_read = 1'b0;
    @(posedge clk); #1;
    chk1("midrst_read", pmem_read, 1'b0);
    chk1("midrst_busy", arb_busy, 1'b0);
    chk("midrst_addr", 128'(pmem_address), 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1("post_rst_idle", arb_busy, 1'b0);

    // Stray pmem_resp in IDLE, then read+write together treated as a write.
    pmem_resp = 1'b1;
    @(negedge clk);
    chk1("stray_iresp", icache_pmem_resp, 1'b0);
    chk1("stray_dresp", dcache_pmem_resp, 1'b0);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    chk1("stray_busy", arb_busy, 1'b0);
    e = '{own_d: 1'b1, addr: 16'h0550, wr: 1'b1, wdata: {4{32'hDEAD_BEEF}}}; sb.push_back(e);
    dcache_pmem_read = 1'b1; dcache_pmem_write = 1'b1;
    dcache_pmem_address = 16'h0557; dcache_pmem_wdata = {4{32'hDEAD_BEEF}};
    @(posedge clk); #1;
    chk1("rw_is_write", pmem_write, 1'b1);
    chk1("rw_no_read", pmem_read, 1'b0);
    mem_serve(2, w);
    dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Sequential arbiter that shares the single physical-memory port between the instruction cache and the data cache of the pipelined LC-3b. It sits between the two L1 caches and physical memory (or L2), grants one 128-bit line transaction at a time, and routes data and response back to the granted cache. Data-cache requests win by default because a D-side miss holds MEM and the whole pipeline. A streak counter prevents I-side starvation.

## Interface
- STARVE_LIMIT, 4: consecutive contended D grants allowed before a waiting I request is forced through (legal range 1-15).
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears FSM and counter.
- icache_pmem_read  in  1  I-side line read request; held until icache_pmem_resp.
- icache_pmem_address  in  16  I-side line address; bits [3:0] ignored.
- icache_pmem_rdata  out  128  line data to I-cache; valid while icache_pmem_resp=1.
- icache_pmem_resp  out  1  one-cycle completion to I-cache.
- dcache_pmem_read  in  1  D-side line read request.
- dcache_pmem_write  in  1  D-side line writeback request.
- dcache_pmem_address  in  16  D-side line address.
- dcache_pmem_wdata  in  128  writeback line.
- dcache_pmem_rdata  out  128  line data to D-cache.
- dcache_pmem_resp  out  1  one-cycle completion to D-cache.
- pmem_read  out  1  read command to memory.
- pmem_write  out  1  write command to memory.
- pmem_address  out  16  latched address, low nibble forced to 0.
- pmem_wdata  out  128  latched writeback line.
- pmem_rdata  in  128  line from memory, valid with pmem_resp.
- pmem_resp  in  1  memory completion, one cycle.
- arb_busy  out  1  high in any non-IDLE state.

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE: no requests -> stay. D request only (read or write) -> SERVE_D. I only -> SERVE_I. Both -> SERVE_D, unless d_streak == STARVE_LIMIT, then SERVE_I.
- On the grant edge, latch address (low nibble zeroed), D write flag, and wdata. These registers drive pmem_*; later changes on requester inputs are ignored until the next grant.
- SERVE_I: pmem_read=1, pmem_write=0 until pmem_resp. On pmem_resp: icache_pmem_resp=1, icache_pmem_rdata=pmem_rdata (combinational pass-through), next state IDLE.
- SERVE_D: pmem_read = !wflag, pmem_write = wflag. On pmem_resp: dcache_pmem_resp=1, dcache_pmem_rdata=pmem_rdata, next state IDLE.
- Non-granted requester's resp stays 0. rdata outputs are don't-care when resp=0; they are driven with pmem_rdata at all times.
- dcache_pmem_read and dcache_pmem_write both high is illegal. The arbiter treats it as a write.
- d_streak, 4 bits, saturating at STARVE_LIMIT:
  - increments on a D grant made while I was also requesting;
  - clears on any I grant;
  - holds on an uncontended D grant.
- The mandatory IDLE cycle after every completion lets the requester drop its request (one cycle after resp), so a stale request is never re-granted.

## Timing
- Reset values: FSM=IDLE, d_streak=0, latched address/wdata/wflag=0. pmem_read, pmem_write, both resps and arb_busy=0.
- Request visible in IDLE at edge t -> state SERVE_x and pmem command asserted from cycle t+1.
- Completion: pmem_resp in cycle r -> requester resp in cycle r (zero added latency). State is IDLE in cycle r+1; the earliest next command is r+2.
- Minimum arbiter overhead per transaction: 2 cycles (grant + IDLE turnaround) beyond memory latency.
- pmem_resp in IDLE is ignored and produces no requester resp.
- Reset asserted mid-transaction: next cycle is IDLE with all commands deasserted. The in-flight transaction is abandoned, and memory is reset by the same signal.
- Requester deasserting its request while granted: the transaction still completes and resp still pulses.

## Test plan
- Reset, then an I read at 0x1234 alone, memory latency 3 -> pmem_address=0x1230 and pmem_read=1 for 3 cycles. icache_pmem_resp pulses once with rdata; arb_busy falls the next cycle.
- I read and D read raised in the same cycle -> D served first. I is granted on the cycle after the IDLE turnaround; each resp goes only to its owner.
- D writeback of 0xAAAA…A to 0x0400 -> pmem_write=1, pmem_read=0, pmem_wdata matches. Changing dcache_pmem_wdata mid-transaction does not alter pmem_wdata.
- I held high while D issues back-to-back requests, STARVE_LIMIT=4 -> exactly 4 D grants, then I granted, then d_streak=0 and D is served again.
- Reset pulsed 2 cycles into a D read -> pmem_read=0 and state IDLE the next cycle, with no dcache_pmem_resp.
- Stray pmem_resp pulse while IDLE, and both D read and write asserted -> no resp generated; then a write command (pmem_write=1) is issued.
